// File: rtl/gate_sweep_ctrl_if.sv
// Handshake/result bundle between a sweep driver (master) and gate_sweep_ctrl (slave).
// The gate output dut_out is sourced from the master side, where the gate under test lives.
interface gate_sweep_ctrl_if #(
   parameter int N_IN = 2
);
   logic                   start;
   logic [N_IN-1:0]        dut_in;
   logic                   dut_out;
   logic                   busy;
   logic                   done;
   logic                   pass;
   logic [N_IN:0]          err_count;
   logic [N_IN-1:0]        fail_idx;
   logic [(1<<N_IN)-1:0]   captured;

   modport master (
      output start, dut_out,
      input  dut_in, busy, done, pass, err_count, fail_idx, captured
   );

   modport slave (
      input  start, dut_out,
      output dut_in, busy, done, pass, err_count, fail_idx, captured
   );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweeper: drives every input vector to a small gate, samples after a settle window
// and compares against EXPECT. Optional macro STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_sweep_ctrl #(
   parameter int                   N_IN   = 2,
   parameter int                   SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b1000
) (
   input  logic              clk,
   input  logic              rst,
   gate_sweep_ctrl_if.slave  bus
);
   localparam int NVEC = 1 << N_IN;
   localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_e;

   state_e              state_q;
   logic [N_IN-1:0]     idx_q;
   logic [CW-1:0]       cnt_q;
   logic [N_IN-1:0]     dut_in_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;
   logic [N_IN:0]       err_q;
   logic [N_IN-1:0]     fail_q;
   logic [NVEC-1:0]     cap_q;
   logic                seen_fail_q;

   logic [N_IN-1:0]     idx_d;
   logic                miss;
   logic                last_vec;
   logic                stop_now;

   assign idx_d    = idx_q + 1'b1;
   assign miss     = (bus.dut_out != EXPECT[idx_q]);
   assign last_vec = (idx_q == N_IN'(NVEC - 1));

`ifdef STOP_ON_FAIL_EN
   assign stop_now = miss;
`else
   assign stop_now = 1'b0;
`endif

   // NOTE: one clocked block with non-blocking assignments; every output is a flop so busy/done never glitch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         dut_in_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         fail_q      <= '0;
         cap_q       <= '0;
         seen_fail_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  idx_q       <= '0;
                  dut_in_q    <= '0;
                  cnt_q       <= CW'(SETTLE - 1);
                  err_q       <= '0;
                  fail_q      <= '0;
                  cap_q       <= '0;
                  pass_q      <= 1'b0;
                  seen_fail_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_q == '0) state_q <= S_SAMPLE;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            S_SAMPLE: begin
               cap_q[idx_q] <= bus.dut_out;
               if (miss) begin
                  err_q       <= err_q + 1'b1;
                  seen_fail_q <= 1'b1;
                  if (!seen_fail_q) fail_q <= idx_q;
               end
               // dut_in keeps the last driven vector once the sweep finishes
               if (last_vec || stop_now) begin
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  idx_q    <= idx_d;
                  dut_in_q <= idx_d;
                  cnt_q    <= CW'(SETTLE - 1);
                  state_q  <= S_SETTLE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               pass_q  <= (err_q == '0);
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.dut_in    = dut_in_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_idx  = fail_q;
   assign bus.captured  = cap_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (default AND expectation, and SETTLE=1 XOR expectation)
// driven by truth-table gate models; expected results come from arithmetic over the truth tables.
module tb_gate_sweep_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gate_sweep_ctrl_if #(.N_IN(2)) ifa ();
   gate_sweep_ctrl_if #(.N_IN(2)) ifb ();

   logic [3:0] tt_a = 4'b1000;
   logic [3:0] tt_b = 4'b0110;
   assign ifa.dut_out = tt_a[ifa.dut_in];
   assign ifb.dut_out = tt_b[ifb.dut_in];

   gate_sweep_ctrl u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXPECT(4'b0110)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   int checks   = 0;
   int failures = 0;
   bit sel      = 1'b0;

   logic [1:0] o_dut_in;
   logic       o_busy, o_done, o_pass;
   logic [2:0] o_err;
   logic [1:0] o_fail;
   logic [3:0] o_cap;

   always_comb begin
      o_dut_in = sel ? ifb.dut_in    : ifa.dut_in;
      o_busy   = sel ? ifb.busy      : ifa.busy;
      o_done   = sel ? ifb.done      : ifa.done;
      o_pass   = sel ? ifb.pass      : ifa.pass;
      o_err    = sel ? ifb.err_count : ifa.err_count;
      o_fail   = sel ? ifb.fail_idx  : ifa.fail_idx;
      o_cap    = sel ? ifb.captured  : ifa.captured;
   end

   task automatic drive_start(input bit which, input logic v);
      if (which) ifb.start = v;
      else       ifa.start = v;
   endtask

   // One sweep on the selected instance; repulse_k = cycle to pulse start (-2 = DONE cycle), rst_k = cycle to reset.
   task automatic run_sweep(input string name, input bit which, input logic [3:0] tt,
                            input int repulse_k, input int rst_k);
      int settle, first, errs, last_v, t_done, dut_e, rp;
      logic [3:0] expv, mism, cap_e;
      sel    = which;
      settle = which ? 1 : 2;
      expv   = which ? 4'b0110 : 4'b1000;
      if (which) tt_b = tt;
      else       tt_a = tt;
      mism  = tt ^ expv;
      first = -1;
      errs  = 0;
      for (int i = 0; i < 4; i++) begin
         if (mism[i]) begin
            errs++;
            if (first < 0) first = i;
         end
      end
      last_v = 3;
      cap_e  = tt;
`ifdef STOP_ON_FAIL_EN
      if (first >= 0) begin
         last_v = first;
         errs   = 1;
         cap_e  = tt & 4'((1 << (first + 1)) - 1);
      end
`endif
      t_done = (last_v + 1) * (settle + 1) + 1;
      rp     = (repulse_k == -2) ? t_done - 1 : repulse_k;

      @(posedge clk); #1;
      drive_start(which, 1'b1);
      @(posedge clk); #1;
      drive_start(which, 1'b0);
      for (int k = 0; k <= t_done; k++) begin
         if (k == rst_k) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            checks++;
            if ({o_dut_in, o_busy, o_done, o_pass, o_err, o_fail, o_cap} !== 14'd0) begin
               failures++;
               $display("FAIL %s.reset_zero got=%b required=0", name,
                        {o_dut_in, o_busy, o_done, o_pass, o_err, o_fail, o_cap});
            end
            return;
         end
         dut_e = k / (settle + 1);
         if (dut_e > last_v) dut_e = last_v;
         checks++;
         if (o_dut_in !== 2'(dut_e)) begin
            failures++;
            $display("FAIL %s.dut_in k=%0d got=%0d required=%0d", name, k, o_dut_in, dut_e);
         end
         checks++;
         if (o_busy !== (k <= t_done - 2)) begin
            failures++;
            $display("FAIL %s.busy k=%0d got=%b required=%b", name, k, o_busy, (k <= t_done - 2));
         end
         checks++;
         if (o_done !== (k == t_done)) begin
            failures++;
            $display("FAIL %s.done k=%0d got=%b required=%b", name, k, o_done, (k == t_done));
         end
         if (k < t_done) begin
            checks++;
            if (o_pass !== 1'b0) begin
               failures++;
               $display("FAIL %s.pass_cleared k=%0d got=%b required=0", name, k, o_pass);
            end
         end else begin
            checks++;
            if (o_pass !== (errs == 0)) begin
               failures++;
               $display("FAIL %s.pass got=%b required=%b", name, o_pass, (errs == 0));
            end
            checks++;
            if (o_err !== 3'(errs)) begin
               failures++;
               $display("FAIL %s.err_count got=%0d required=%0d", name, o_err, errs);
            end
            checks++;
            if (o_fail !== 2'((first < 0) ? 0 : first)) begin
               failures++;
               $display("FAIL %s.fail_idx got=%0d required=%0d", name, o_fail, (first < 0) ? 0 : first);
            end
            checks++;
            if (o_cap !== cap_e) begin
               failures++;
               $display("FAIL %s.captured got=%b required=%b", name, o_cap, cap_e);
            end
         end
         drive_start(which, (k == rp) ? 1'b1 : 1'b0);
         if (k < t_done) begin
            @(posedge clk); #1;
         end
      end
      drive_start(which, 1'b0);
      for (int h = 0; h < 2; h++) begin
         @(posedge clk); #1;
         checks++;
         if ({o_busy, o_done} !== 2'b00 || o_pass !== (errs == 0) || o_err !== 3'(errs) ||
             o_cap !== cap_e || o_dut_in !== 2'(last_v)) begin
            failures++;
            $display("FAIL %s.hold h=%0d got busy=%b done=%b pass=%b err=%0d cap=%b dut_in=%0d required busy=0 done=0 pass=%b err=%0d cap=%b dut_in=%0d",
                     name, h, o_busy, o_done, o_pass, o_err, o_cap, o_dut_in,
                     (errs == 0), errs, cap_e, last_v);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({ifa.dut_in, ifa.busy, ifa.done, ifa.pass, ifa.err_count, ifa.fail_idx, ifa.captured} !== 14'd0) begin
         failures++;
         $display("FAIL reset.dut_a got=%b required=0",
                  {ifa.dut_in, ifa.busy, ifa.done, ifa.pass, ifa.err_count, ifa.fail_idx, ifa.captured});
      end
      checks++;
      if ({ifb.dut_in, ifb.busy, ifb.done, ifb.pass, ifb.err_count, ifb.fail_idx, ifb.captured} !== 14'd0) begin
         failures++;
         $display("FAIL reset.dut_b got=%b required=0",
                  {ifb.dut_in, ifb.busy, ifb.done, ifb.pass, ifb.err_count, ifb.fail_idx, ifb.captured});
      end
      rst = 1'b0;
   endtask

   task automatic test_and();
      run_sweep("and", 1'b0, 4'b1000, -1, -1);
   endtask

   task automatic test_or();
      run_sweep("or", 1'b0, 4'b1110, -1, -1);
   endtask

   task automatic test_xor_settle1();
      run_sweep("xor_s1", 1'b1, 4'b0110, -1, -1);
   endtask

   task automatic test_start_ignored();
      run_sweep("restart_busy", 1'b0, 4'b1000, 5, -1);
      run_sweep("restart_done", 1'b0, 4'b1000, -2, -1);
   endtask

   task automatic test_reset_mid_sweep();
      run_sweep("mid_rst", 1'b0, 4'b1110, -1, 4);
      run_sweep("after_rst", 1'b0, 4'b1000, -1, -1);
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         run_sweep($sformatf("rand%0d", r), r[0], 4'($urandom), -1, -1);
      end
   endtask

   initial begin
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      test_reset();
      test_and();
      test_or();
      test_xor_settle1();
      test_start_ignored();
      test_reset_mid_sweep();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic test_back_to_back();
      run_sweep("b2b_0", 1'b1, 4'b1001, -1, -1);
      run_sweep("b2b_1", 1'b1, 4'b0110, -1, -1);
   endtask
endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Self-checking stimulus sequencer for a small combinational gate under test (AND/OR/XOR-class, N_IN inputs, 1 output). On start it walks dut_in through every input combination 0..2^N_IN-1. It holds each vector for a settle window, then samples dut_out and compares it against a parameterised expected truth table. It reports pass/fail, the error count, the first failing index and the full captured truth table. It replaces hand-written per-gate benches in the gate projects and sits between a top-level bench/driver and the gate instance.

Parameters:
N_IN, 2, number of gate inputs (1..4)
SETTLE, 2, cycles each vector is held before sampling (>=1)
EXPECT, 4'b1000, expected output per vector; bit i = expected dut_out for dut_in==i; width 2^N_IN (default = AND truth table)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin sweep; sampled only in IDLE
dut_in  output  N_IN  vector driven to gate under test
dut_out  input  1  gate output
busy  output  1  high from the cycle after start is accepted until DONE is entered
done  output  1  one-cycle pulse at sweep end
pass  output  1  1 if the last sweep had zero mismatches
err_count  output  N_IN+1  mismatches in the last/current sweep
fail_idx  output  N_IN  index of first mismatch; 0 if none
captured  output  2^N_IN  sampled dut_out per vector; bit i = vector i

Behaviour:
- Reset (rst=1 at edge, any state, including mid-sweep): state=IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0, captured=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on start=1: idx<=0, dut_in<=0, cnt<=SETTLE-1, err_count<=0, fail_idx<=0, captured<=0, pass<=0 -> SETTLE. Otherwise hold all outputs, including the last sweep's results.
- SETTLE: if cnt==0 -> SAMPLE, else cnt<=cnt-1. Occupies exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - captured[idx]<=dut_out.
  - If dut_out!=EXPECT[idx]: err_count<=err_count+1; if this is the first mismatch, fail_idx<=idx.
  - If idx==2^N_IN-1 -> DONE. Else idx<=idx+1, dut_in<=idx+1, cnt<=SETTLE-1 -> SETTLE.
- DONE (1 cycle):
  - done=1.
  - pass<=(err_count==0), using the final count including the last sample.
  - -> IDLE. dut_in holds the last vector until the next start.
- Per-vector time = SETTLE+1 cycles. done asserts 2^N_IN*(SETTLE+1)+1 cycles after the edge that accepted start (defaults: 13).
- busy=1 in SETTLE and SAMPLE; 0 in IDLE and DONE.
- start while busy, or in DONE, is ignored; it is not queued.
- err_count width N_IN+1 holds up to 2^N_IN; no saturation is needed.
- The first-mismatch flag is internal; it clears on start and on reset.
- dut_out is sampled only in SAMPLE; glitches during SETTLE are ignored.

Optional Feature:
Macro STOP_ON_FAIL_EN.
- Defined: a mismatch in SAMPLE goes directly to DONE. Remaining vectors are not driven; their captured bits stay 0. err_count=1, pass=0.
- Undefined: the sweep always covers all 2^N_IN vectors.

Test Plan:
- Defaults, DUT=AND, start pulse -> done 13 cycles later; pass=1, err_count=0, fail_idx=0, captured=4'b1000; dut_in sequence 0,1,2,3, each held 3 cycles.
- Defaults, DUT=OR (EXPECT still AND) -> pass=0, err_count=2, fail_idx=1, captured=4'b1110.
- SETTLE=1, DUT=XOR, EXPECT=4'b0110 -> done 9 cycles after start; pass=1, captured=4'b0110.
- start re-pulsed while busy at cycle 5 -> ignored, done still at cycle 13; then rst=1 mid-sweep of a second run -> next cycle all outputs 0, state IDLE; a new start runs a clean sweep.
- STOP_ON_FAIL_EN defined, DUT=OR -> done after the vector-1 sample (cycle 7); err_count=1, fail_idx=1, pass=0, captured=4'b0010.
